// File: rtl/jtag_tap_dtm.sv
// rtl/jtag_tap_dtm.sv - JTAG TAP with debug transport module, TCK oversampled in the clk domain
module jtag_tap_dtm #(
   parameter logic [31:0] IDCODE = 32'h0000_0001,
   parameter int          ABITS  = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tclk,
   input  logic             tms,
   input  logic             tdi,
   input  logic             trst,
   output logic             tdo,
   output logic             tdo_en,
   output logic             dmi_req_valid,
   input  logic             dmi_req_ready,
   output logic [ABITS-1:0] dmi_req_addr,
   output logic [31:0]      dmi_req_data,
   output logic [1:0]       dmi_req_op,
   input  logic             dmi_resp_valid,
   input  logic [31:0]      dmi_resp_data,
   input  logic [1:0]       dmi_resp_op
);
   localparam int DR_W = ABITS + 34;
   localparam int MW   = $clog2(DR_W);

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
   } tap_state_t;

   tap_state_t      state, state_nxt;
   logic [2:0]      tclk_q;
   logic [1:0]      tms_q, tdi_q, trst_q;
   logic            tck_rise, tck_fall, tms_s, tdi_s, trst_ok;
   logic            capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
   logic [4:0]      ir, ir_sr;
   logic [DR_W-1:0] dr_sr, dr_shifted;
   logic [MW-1:0]   dr_msb;
   logic            sel_idcode, sel_dtmcs, sel_dmi;
   logic [31:0]     dtmcs_cap, resp_data;
   logic [1:0]      dmi_stat, dr_op;
   logic            pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tclk_q <= '0;
         tms_q  <= '0;
         tdi_q  <= '0;
         trst_q <= '0;
      end else begin
         tclk_q <= {tclk_q[1:0], tclk};
         tms_q  <= {tms_q[0], tms};
         tdi_q  <= {tdi_q[0], tdi};
         trst_q <= {trst_q[0], trst};
      end
   end

   // tms/tdi are taken from the same sync stage that reports the tclk edge
   assign trst_ok  = trst_q[1];
   assign tck_rise = tclk_q[1] & ~tclk_q[2] & trst_ok;
   assign tck_fall = ~tclk_q[1] & tclk_q[2] & trst_ok;
   assign tms_s    = tms_q[1];
   assign tdi_s    = tdi_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        state <= TLR;
      else if (!trst_ok) state <= TLR;
      else if (tck_rise) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TLR:     state_nxt = tms_s ? TLR    : RTI;
         RTI:     state_nxt = tms_s ? SEL_DR : RTI;
         SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
         CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
         SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
         EX1_DR:  state_nxt = tms_s ? UPD_DR : PA_DR;
         PA_DR:   state_nxt = tms_s ? EX2_DR : PA_DR;
         EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
         UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
         SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
         CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
         SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
         EX1_IR:  state_nxt = tms_s ? UPD_IR : PA_IR;
         PA_IR:   state_nxt = tms_s ? EX2_IR : PA_IR;
         EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
         UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
         default: state_nxt = TLR;
      endcase
   end

   always_comb begin
      tdo_en     = 1'b0;
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      capture_ir = 1'b0;
      shift_ir   = 1'b0;
      update_ir  = 1'b0;
      case (state)
         CAP_DR:  capture_dr = tck_rise;
         SH_DR:   begin tdo_en = 1'b1; shift_dr = tck_rise; end
         UPD_DR:  update_dr = tck_fall;
         CAP_IR:  capture_ir = tck_rise;
         SH_IR:   begin tdo_en = 1'b1; shift_ir = tck_rise; end
         UPD_IR:  update_ir = tck_fall;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir    <= 5'h01;
         ir_sr <= '0;
      end else begin
         if (state == TLR || !trst_ok) ir <= 5'h01;
         else if (update_ir)           ir <= ir_sr;
         if (capture_ir)    ir_sr <= 5'b00001;
         else if (shift_ir) ir_sr <= {tdi_s, ir_sr[4:1]};
      end
   end

   always_comb begin
      sel_idcode = (ir == 5'h01);
      sel_dtmcs  = (ir == 5'h10);
      sel_dmi    = (ir == 5'h11);
      if (sel_dmi)                      dr_msb = MW'(DR_W - 1);
      else if (sel_idcode || sel_dtmcs) dr_msb = MW'(31);
      else                              dr_msb = '0;
      dtmcs_cap = {14'd0, 2'b00, 1'b0, 3'd1, dmi_stat, 6'(ABITS), 4'd1};
      dr_op     = dr_sr[1:0];
   end

   // tdi enters at the top of the currently selected register length
   always_comb begin
      dr_shifted         = {1'b0, dr_sr[DR_W-1:1]};
      dr_shifted[dr_msb] = tdi_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dr_sr <= '0;
      end else if (capture_dr) begin
         if (sel_dmi)         dr_sr <= {dmi_req_addr, resp_data, pending ? 2'd3 : dmi_stat};
         else if (sel_dtmcs)  dr_sr <= DR_W'(dtmcs_cap);
         else if (sel_idcode) dr_sr <= DR_W'({IDCODE[31:1], 1'b1});
         else                 dr_sr <= '0;
      end else if (shift_dr) begin
         dr_sr <= dr_shifted;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                tdo <= 1'b0;
      else if (tck_fall && tdo_en) tdo <= (state == SH_IR) ? ir_sr[0] : dr_sr[0];
   end

   // Later assignments win: a response landing in the same clk as a DTMCS clear still retires it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmi_req_valid <= 1'b0;
         dmi_req_addr  <= '0;
         dmi_req_data  <= '0;
         dmi_req_op    <= '0;
         pending       <= 1'b0;
         dmi_stat      <= 2'd0;
         resp_data     <= '0;
      end else begin
         if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
         if (update_dr && sel_dtmcs) begin
            if (dr_sr[16] || dr_sr[17]) dmi_stat <= 2'd0;
            if (dr_sr[17]) begin
               pending       <= 1'b0;
               dmi_req_valid <= 1'b0;
            end
         end else if (update_dr && sel_dmi && (dr_op == 2'd1 || dr_op == 2'd2)) begin
            if (pending) begin
               dmi_stat <= 2'd3;
            end else if (dmi_stat == 2'd0) begin
               dmi_req_addr  <= dr_sr[DR_W-1:34];
               dmi_req_data  <= dr_sr[33:2];
               dmi_req_op    <= dr_op;
               dmi_req_valid <= 1'b1;
               pending       <= 1'b1;
            end
         end
         if (capture_dr && sel_dmi && pending) dmi_stat <= 2'd3;
         if (dmi_resp_valid && pending) begin
            resp_data <= dmi_resp_data;
            if (dmi_resp_op == 2'd2) dmi_stat <= 2'd2;
            pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_jtag_tap_dtm.sv
// tb/tb_jtag_tap_dtm.sv - randomized scoreboard bench for jtag_tap_dtm
module tb_jtag_tap_dtm;
   localparam int          ABITS  = 7;
   localparam int          HALF   = 4;
   localparam logic [31:0] IDCODE = 32'h0000_0001;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             tclk = 1'b0, tms = 1'b0, tdi = 1'b0, trst = 1'b1;
   logic             tdo, tdo_en;
   logic             dmi_req_valid, dmi_req_ready = 1'b0;
   logic [ABITS-1:0] dmi_req_addr;
   logic [31:0]      dmi_req_data;
   logic [1:0]       dmi_req_op;
   logic             dmi_resp_valid = 1'b0;
   logic [31:0]      dmi_resp_data = '0;
   logic [1:0]       dmi_resp_op = '0;

   jtag_tap_dtm #(.IDCODE(IDCODE), .ABITS(ABITS)) dut (
      .clk(clk), .rst_n(rst_n), .tclk(tclk), .tms(tms), .tdi(tdi), .trst(trst),
      .tdo(tdo), .tdo_en(tdo_en),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
      .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op)
   );

   always #5 clk = ~clk;

   typedef struct { string name; logic [63:0] val; } exp_t;
   exp_t        scan_exp_q[$];
   logic [63:0] scan_act_q[$];
   logic [63:0] req_exp_q[$];
   int total = 0;
   int bad   = 0;

   // reference view of the debug transport
   logic [ABITS-1:0] m_addr = '0;
   logic [31:0]      m_data = '0;
   int               m_stat = 0;
   bit               m_pending = 0, m_outstanding = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endfunction

   function automatic logic [63:0] dmi_word(input logic [ABITS-1:0] a, input logic [31:0] d, input int op);
      return (64'(a) << 34) | (64'(d) << 2) | 64'(op);
   endfunction

   function automatic void expect_scan(input string name, input logic [63:0] v);
      exp_t e;
      e.name = name;
      e.val  = v;
      scan_exp_q.push_back(e);
   endfunction

   task automatic tck(input logic t_ms, input logic t_di, output logic t_do);
      tms = t_ms;
      tdi = t_di;
      repeat (HALF) @(posedge clk);
      #1 tclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 tclk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 t_do = tdo;
   endtask

   task automatic scan(input bit is_ir, input int len, input logic [63:0] din, output logic [63:0] dout);
      logic b;
      tck(1'b1, 1'b0, b);
      if (is_ir) tck(1'b1, 1'b0, b);
      tck(1'b0, 1'b0, b);
      tck(1'b0, 1'b0, b);
      dout    = '0;
      dout[0] = b;
      for (int i = 0; i < len; i++) begin
         tck(i == len - 1, din[i], b);
         if (i < len - 1) dout[i+1] = b;
      end
      tck(1'b1, 1'b0, b);
      tck(1'b0, 1'b0, b);
      scan_act_q.push_back(dout);
   endtask

   task automatic tap_reset();
      logic b;
      repeat (5) tck(1'b1, 1'b0, b);
      tck(1'b0, 1'b0, b);
   endtask

   task automatic set_ir(input logic [4:0] v);
      logic [63:0] dout;
      expect_scan("ir_capture", 64'd1);
      scan(1'b1, 5, 64'(v), dout);
   endtask

   task automatic dtmcs_scan(input logic [31:0] din);
      logic [63:0] dout;
      expect_scan("dtmcs_capture", 64'(4096 + m_stat * 1024 + ABITS * 16 + 1));
      scan(1'b0, 32, 64'(din), dout);
      if (din[17]) begin
         m_stat    = 0;
         m_pending = 0;
         if (m_outstanding) begin
            void'(req_exp_q.pop_back());
            m_outstanding = 0;
         end
      end else if (din[16]) begin
         m_stat = 0;
      end
   endtask

   task automatic dmi_scan(input logic [ABITS-1:0] a, input logic [31:0] d, input int op, output bit issued);
      logic [63:0] dout;
      expect_scan("dmi_capture", dmi_word(m_addr, m_data, m_pending ? 3 : m_stat));
      if (m_pending) m_stat = 3;
      scan(1'b0, ABITS + 34, dmi_word(a, d, op), dout);
      issued = 0;
      if (op == 1 || op == 2) begin
         if (m_pending) begin
            m_stat = 3;
         end else if (m_stat == 0) begin
            issued        = 1;
            m_pending     = 1;
            m_outstanding = 1;
            m_addr        = a;
            req_exp_q.push_back(dmi_word(a, d, op));
         end
      end
   endtask

   task automatic handshake(input int dly);
      int n = 0;
      while (dmi_req_valid !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      check("req_valid_seen", 64'(dmi_req_valid), 64'd1);
      repeat (dly) @(posedge clk);
      #1 dmi_req_ready = 1'b1;
      @(posedge clk);
      #1 dmi_req_ready = 1'b0;
      m_outstanding = 0;
      check("req_valid_drop", 64'(dmi_req_valid), 64'd0);
   endtask

   task automatic respond(input int dly, input logic [31:0] d, input bit fail);
      repeat (dly) @(posedge clk);
      #1;
      dmi_resp_valid = 1'b1;
      dmi_resp_data  = d;
      dmi_resp_op    = fail ? 2'd2 : 2'd0;
      @(posedge clk);
      #1 dmi_resp_valid = 1'b0;
      if (m_pending) begin
         m_data = d;
         if (fail) m_stat = 2;
         m_pending = 0;
      end
   endtask

   initial begin : monitor
      logic [63:0] held, cur, a, r;
      bit          held_v;
      exp_t        e;
      held_v = 0;
      forever begin
         @(negedge clk);
         while (scan_act_q.size() > 0) begin
            a = scan_act_q.pop_front();
            if (scan_exp_q.size() > 0) begin
               e = scan_exp_q.pop_front();
            end else begin
               e.name = "scan_extra";
               e.val  = '1;
            end
            check(e.name, a, e.val);
         end
         if (dmi_req_valid) begin
            cur = 64'({dmi_req_addr, dmi_req_data, dmi_req_op});
            if (held_v) check("req_stable", cur, held);
            if (dmi_req_ready) begin
               r = (req_exp_q.size() > 0) ? req_exp_q.pop_front() : '1;
               check("dmi_req", cur, r);
               held_v = 0;
            end else begin
               held   = cur;
               held_v = 1;
            end
         end else begin
            held_v = 0;
         end
      end
   end

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin : main
      logic        b;
      bit          issued;
      logic [63:0] dout;
      int          op;
      repeat (4) @(posedge clk);
      #1;
      check("rst_tdo", 64'(tdo), 64'd0);
      check("rst_tdo_en", 64'(tdo_en), 64'd0);
      check("rst_req_valid", 64'(dmi_req_valid), 64'd0);
      check("rst_req_fields", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 tap_reset();

      expect_scan("idcode", 64'(IDCODE | 32'd1));
      scan(1'b0, 32, 64'd0, dout);
      set_ir(5'h10);
      dtmcs_scan(32'd0);

      set_ir(5'h11);
      dmi_scan(7'h10, 32'hDEAD_BEEF, 2, issued);
      handshake(3);
      respond(2, $urandom, 1'b0);
      dmi_scan(7'h11, 32'd0, 1, issued);
      handshake(1);
      respond(1, 32'h1234_5678, 1'b0);
      dmi_scan(7'h00, 32'd0, 0, issued);

      for (int i = 0; i < 14; i++) begin
         op = $urandom_range(0, 3);
         dmi_scan(7'($urandom), $urandom, op, issued);
         if (issued) begin
            handshake($urandom_range(0, 3));
            respond($urandom_range(0, 3), $urandom, $urandom_range(0, 3) == 0);
         end
         if (m_stat != 0 && $urandom_range(0, 1) == 1) begin
            set_ir(5'h10);
            dtmcs_scan(32'h0001_0000);
            set_ir(5'h11);
         end
      end

      set_ir(5'h10);
      dtmcs_scan(32'h0001_0000);
      set_ir(5'h11);
      dmi_scan(7'h05, $urandom, 2, issued);
      handshake(0);
      dmi_scan(7'h06, $urandom, 1, issued);
      check("busy_no_req", 64'(dmi_req_valid), 64'd0);
      set_ir(5'h10);
      dtmcs_scan(32'd0);
      respond(2, 32'hA5A5_0F0F, 1'b0);
      dtmcs_scan(32'h0001_0000);
      dtmcs_scan(32'd0);

      set_ir(5'h11);
      dmi_scan(7'h22, $urandom, 2, issued);
      set_ir(5'h10);
      dtmcs_scan(32'h0002_0000);
      check("cancel_req_valid", 64'(dmi_req_valid), 64'd0);
      respond(1, 32'hFFFF_0000, 1'b1);
      set_ir(5'h11);
      dmi_scan(7'h00, 32'd0, 0, issued);

      tck(1'b1, 1'b0, b);
      tck(1'b0, 1'b0, b);
      tck(1'b0, 1'b0, b);
      tck(1'b0, 1'b1, b);
      tck(1'b0, 1'b0, b);
      check("shift_tdo_en", 64'(tdo_en), 64'd1);
      trst = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("trst_tdo_en", 64'(tdo_en), 64'd0);
      trst = 1'b1;
      repeat (4) @(posedge clk);
      #1 tck(1'b0, 1'b0, b);
      expect_scan("idcode_after_trst", 64'(IDCODE | 32'd1));
      scan(1'b0, 32, 64'($urandom), dout);

      set_ir(5'h10);
      tck(1'b1, 1'b0, b);
      tck(1'b0, 1'b0, b);
      tck(1'b1, 1'b0, b);
      tck(1'b0, 1'b0, b);
      tap_reset();
      expect_scan("idcode_after_tms_reset", 64'(IDCODE | 32'd1));
      scan(1'b0, 32, 64'd0, dout);

      repeat (20) @(posedge clk);
      #1;
      check("scan_exp_drained", 64'(scan_exp_q.size()), 64'd0);
      check("req_exp_drained", 64'(req_exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jtag_tap_dtm.md
JTAG_TAP_DTM -- requirements
Module: jtag_tap_dtm

Interface
REQ-001 Parameter IDCODE, 32'h0000_0001, value captured in IDCODE DR (bit 0 forced 1).
REQ-002 Parameter ABITS, 7, DMI address width; DMI DR length = ABITS+34 (41).
REQ-003 clk  in  1  system clock; all logic on rising edge; only clock in the block.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 tclk  in  1  JTAG TCK, asynchronous, sampled in clk domain.
REQ-006 tms, tdi  in  1 each  JTAG TMS/TDI, asynchronous.
REQ-007 trst  in  1  JTAG TRST, active-low, asynchronous.
REQ-008 tdo  out  1  JTAG TDO; tdo_en  out  1  high only in Shift-IR/Shift-DR.
REQ-009 dmi_req_valid  out  1; dmi_req_ready  in  1; dmi_req_addr  out  ABITS; dmi_req_data  out  32; dmi_req_op  out  2 (1 read, 2 write).
REQ-010 dmi_resp_valid  in  1; dmi_resp_data  in  32; dmi_resp_op  in  2 (0 ok, 2 failed).

Function
REQ-011 tclk, tms, tdi, trst pass through 2-flop synchronizers; tclk rise/fall detected by 3rd flop; detect latency 3 clk.
REQ-012 Correct operation requires tclk high and low each >=4 clk; shorter pulses are out of spec.
REQ-013 On tclk rise: TAP state advances per IEEE 1149.1 16-state graph using synced tms; shift registers shift in synced tdi (LSB first toward TDO).
REQ-014 Synced trst low forces Test-Logic-Reset within 3 clk, regardless of tclk.
REQ-015 Five tms=1 rising edges from any state reach Test-Logic-Reset.
REQ-016 IR 5 bits; Test-Logic-Reset loads IR=0x01; Capture-IR loads 5'b00001; Update-IR latches shifted value.
REQ-017 IR decode: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (ABITS+34b), all else BYPASS (1b, captures 0).
REQ-018 tdo updates on detected tclk fall from shift-register LSB; holds otherwise; reset value 0.
REQ-019 DTMCS capture: [17:16]=0, [14:12]=1 idle, [11:10]=dmistat, [9:4]=ABITS, [3:0]=1, rest 0.
REQ-020 DMI capture: {addr[ABITS+33:34]=last req addr, data[33:2]=last resp data, op[1:0]=pending?3:dmistat}.
REQ-021 Update-DR DMI with op 1/2, dmistat=0, no pending request: latch addr/data/op, assert dmi_req_valid next clk.
REQ-022 dmi_req_valid held with stable addr/data/op until clk where dmi_req_ready=1; then deasserts; pending stays set until dmi_resp_valid.
REQ-023 dmi_resp_valid: latch dmi_resp_data; if dmi_resp_op=2 set dmistat=2 (sticky); clear pending.
REQ-024 Update-DR DMI while pending: request dropped, dmistat=3 (sticky); op 0 or op 3: no request.
REQ-025 Capture-DR DMI while pending sets dmistat=3.
REQ-026 Update-DR DTMCS bit16=1 clears dmistat; bit17=1 clears dmistat, pending and dmi_req_valid.
REQ-027 dmi_resp_valid without pending: ignored.

Reset
REQ-028 rst_n low: TAP=Test-Logic-Reset, IR=0x01, all shift regs 0, tdo=0, tdo_en=0, dmi_req_valid=0, req fields 0, pending=0, dmistat=0, resp data 0, synchronizers 0.
REQ-029 Test-Logic-Reset (via tms/trst) resets IR only; DMI pending/dmistat/outstanding handshake unaffected.
REQ-030 rst_n deassertion mid-scan: block restarts in Test-Logic-Reset; host must re-sync with 5 tms=1.

Verification
REQ-031 Reset, 5 tms=1, Run-Test/Idle, Shift-DR 32 bits -> tdo returns IDCODE LSB first (0x00000001).
REQ-032 IR=0x10, Shift-DR 32 -> 0x00001071 (idle=1, dmistat=0, abits=7, version=1).
REQ-033 IR=0x11, shift {addr=0x10, data=0xDEADBEEF, op=2}, Update-DR, ready after 3 clk -> one req valid cycle set with those fields; resp ok 0 -> next capture op=0.
REQ-034 Read op=1 addr 0x11, resp data 0x12345678 -> next DMI scan returns data 0x12345678 op 0.
REQ-035 Update-DR DMI while pending -> no new req, capture op=3, DTMCS dmistat=3; DTMCS write bit16=1 -> dmistat 0.
REQ-036 trst pulse low during Shift-DR -> Test-Logic-Reset, IR=0x01, tdo_en=0 within 3 clk.
